// File: rtl/beta_prefetch_buffer.sv
// Instruction prefetch buffer: issues word fetches, tracks outstanding grants,
// and discards stale responses after a flush. Define BETA_PFB_BYPASS_EN for a same-cycle response bypass.
module beta_prefetch_buffer #(
  parameter int                   DataWidth      = 32,
  parameter int                   Depth          = 4,
  parameter int                   MaxOutstanding = 2,
  parameter logic [DataWidth-1:0] BootAddr       = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_en_i,
  input  logic                   flush_i,
  input  logic [DataWidth-1:0]   flush_pc_i,
  output logic                   instr_req_o,
  output logic [DataWidth-1:0]   instr_addr_o,
  input  logic                   instr_ready_i,
  input  logic                   instr_valid_i,
  input  logic [DataWidth-1:0]   instr_rdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_instr_o,
  output logic [DataWidth-1:0]   out_pc_o,
  output logic [$clog2(Depth):0] pfb_count_o,
  output logic                   pfb_busy_o
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam logic [DataWidth-1:0] Step    = DataWidth'(DataWidth / 8);
  localparam logic [CW:0]          DepthV  = (CW + 1)'(Depth);
  localparam logic [CW-1:0]        MaxOutV = CW'(MaxOutstanding);
  localparam logic [CW-1:0]        OneC    = CW'(1);
  localparam logic [PW-1:0]        OneP    = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       discard_q, discard_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DataWidth-1:0] fetch_addr_q, fetch_addr_d;
  logic [DataWidth-1:0] resp_pc_q, resp_pc_d;
  logic [DataWidth-1:0] instr_mem_q [Depth];
  logic [DataWidth-1:0] pc_mem_q [Depth];

  logic          grant, resp_acc, drop, push, fifo_pop, pop;
  logic          byp_hit, byp_take;
  logic [CW:0]   occ_q, occ_d;

  // Responses with nothing outstanding are strays and never reach the FIFO.
  assign grant    = instr_req_o & instr_ready_i;
  assign resp_acc = instr_valid_i & (outst_q != '0);
  assign drop     = resp_acc & (discard_q != '0);

`ifdef BETA_PFB_BYPASS_EN
  assign byp_hit = (count_q == '0) & (discard_q == '0) & resp_acc & ~flush_i;
`else
  assign byp_hit = 1'b0;
`endif

  assign out_valid_o = (count_q != '0) | byp_hit;
  assign out_instr_o = byp_hit ? instr_rdata_i : instr_mem_q[rd_ptr_q];
  assign out_pc_o    = byp_hit ? resp_pc_q : pc_mem_q[rd_ptr_q];

  assign pop      = out_valid_o & out_ready_i & ~flush_i;
  assign byp_take = byp_hit & out_ready_i;
  assign fifo_pop = pop & (count_q != '0);
  assign push     = resp_acc & ~drop & ~flush_i & ~byp_take;

  assign occ_q = {1'b0, count_q} + {1'b0, outst_q};
  assign occ_d = {1'b0, count_d} + {1'b0, outst_d};

  assign instr_req_o  = (state_q == RUN) & fetch_en_i & (outst_q < MaxOutV) & (occ_q < DepthV);
  assign instr_addr_o = fetch_addr_q;
  assign pfb_count_o  = count_q;
  assign pfb_busy_o   = (outst_q != '0) | (discard_q != '0);

  always_comb begin
    count_d      = count_q;
    outst_d      = outst_q;
    discard_d    = discard_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;

    if (grant && !resp_acc)      outst_d = outst_q + OneC;
    else if (!grant && resp_acc) outst_d = outst_q - OneC;

    if (flush_i) begin
      // Everything still in flight at the redirect belongs to the old stream.
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      discard_d    = outst_d;
      fetch_addr_d = flush_pc_i;
      resp_pc_d    = flush_pc_i;
    end else begin
      if (drop) discard_d = discard_q - OneC;
      if (grant) fetch_addr_d = fetch_addr_q + Step;
      if (push || byp_take) resp_pc_d = resp_pc_q + Step;
      if (push) wr_ptr_d = wr_ptr_q + OneP;
      if (fifo_pop) rd_ptr_d = rd_ptr_q + OneP;
      if (push && !fifo_pop)      count_d = count_q + OneC;
      else if (!push && fifo_pop) count_d = count_q - OneC;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_en_i) state_d = RUN;
      RUN: begin
        if (!fetch_en_i && (outst_q == '0)) state_d = IDLE;
        else if (occ_d == DepthV)            state_d = FULL;
      end
      FULL: begin
        if (!fetch_en_i && (outst_q == '0)) state_d = IDLE;
        else if (occ_d < DepthV)             state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= BootAddr;
      resp_pc_q    <= BootAddr;
      for (int i = 0; i < Depth; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= instr_rdata_i;
        pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      end
    end
  end

endmodule

// File: doc/beta_prefetch_buffer.md
BETA_PREFETCH_BUFFER -- requirements
Module: beta_prefetch_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning instruction and address width.
REQ-002 SHALL have parameter Depth, default 4, meaning FIFO entries; power of 2 and >=2.
REQ-003 SHALL have parameter MaxOutstanding, default 2, meaning granted requests without a response; range 1..Depth.
REQ-004 SHALL have parameter BootAddr, default 32'h0000_0000, meaning first fetch address after reset.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk_i  in  1  clock; all state on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 fetch_en_i  in  1  permits issuing new requests.
REQ-009 flush_i, flush_pc_i  in  1, DataWidth  redirect on branch or trap, with the new fetch PC.
REQ-010 instr_req_o, instr_addr_o  out  1, DataWidth  memory request and word address.
REQ-011 instr_ready_i  in  1  grant; the request is accepted when instr_req_o and instr_ready_i are both high.
REQ-012 instr_valid_i, instr_rdata_i  in  1, DataWidth  in-order response, at least 1 cycle after its grant.
REQ-013 out_valid_o, out_ready_i  out/in  1, 1  decode handshake.
REQ-014 out_instr_o, out_pc_o  out  DataWidth each  head instruction and its PC.
REQ-015 pfb_count_o  out  $clog2(Depth)+1  occupied FIFO entries.
REQ-016 pfb_busy_o  out  1  high while requests are outstanding or a discard is pending.

Function
REQ-017 FSM states SHALL be:
  - IDLE: entered from reset.
  - RUN: entered from IDLE when fetch_en_i=1.
  - FULL: entered when count+outstanding==Depth.
  - RUN is re-entered from FULL when a pop frees a slot.
  - Any state returns to IDLE when fetch_en_i=0 and outstanding==0.
REQ-018 instr_req_o SHALL be high in RUN only when fetch_en_i=1, outstanding<MaxOutstanding and count+outstanding<Depth.
REQ-019 Once raised, instr_req_o and instr_addr_o SHALL hold stable until granted, except as covered by REQ-023.
REQ-020 On each grant, the fetch address SHALL advance by DataWidth/8 and wrap modulo 2^DataWidth.
REQ-021 Each valid response SHALL be pushed with PC equal to response-PC, and response-PC SHALL then advance by DataWidth/8.
REQ-022 A pop SHALL occur when out_valid_o=1 and out_ready_i=1.
  - A simultaneous push and pop keeps count unchanged.
  - A push is never dropped, because issue is bounded by REQ-018.
REQ-023 Flush SHALL behave as follows:
  - On flush_i=1, the FIFO is emptied and fetch address and response-PC are loaded with flush_pc_i in the next cycle.
  - discard count is loaded with outstanding, plus 1 if granted that cycle, minus 1 if a response arrived that cycle.
  - An ungranted pending request is withdrawn.
REQ-024 While discard count>0, responses SHALL be dropped and discard count decremented, and no response SHALL be pushed.
  - New requests may still issue; their grants count as outstanding.
REQ-025 A flush SHALL override a same-cycle push and pop.
  - out_valid_o is 0 in the cycle after the flush.
REQ-026 Latency SHALL be: response cycle N gives out_valid_o at cycle N+1 (bypass disabled).
REQ-027 An instr_valid_i arriving with outstanding==0 and discard count==0 SHALL be ignored.

Reset
REQ-028 On rst_i, all of the following SHALL take effect immediately:
  - state is IDLE.
  - count, outstanding and discard count are 0.
  - fetch address and response-PC are BootAddr.
  - instr_req_o, out_valid_o and pfb_busy_o are 0.
  - instr_addr_o is BootAddr.
  - out_instr_o and out_pc_o are 0.
REQ-029 Reset asserted mid-transaction SHALL forget all outstanding requests.
  - Responses arriving after reset release with outstanding==0 are ignored per REQ-027.

Configuration
REQ-030 Macro BETA_PFB_BYPASS_EN SHALL be supported.
  - When defined: if the FIFO is empty, discard count==0 and instr_valid_i=1, out_valid_o SHALL be high combinationally with instr_rdata_i and response-PC in the same cycle.
  - If out_ready_i is also 1, the response SHALL be consumed without a push.
  - When undefined: out_valid_o SHALL be driven only from the FIFO head register, per REQ-026.

Verification
REQ-031 Reset, fetch_en_i=1, instr_ready_i=1 and 1-cycle response with rdata=A0+k -> addresses 0,4,8,C; outputs (A0,0),(A1,4) in order; out_valid_o first high 2 cycles after first grant.
REQ-032 Depth=4, out_ready_i=0 -> exactly 4 grants; state FULL; pfb_count_o=4; instr_req_o=0; one pop -> exactly one new request.
REQ-033 Two requests outstanding, flush_i with flush_pc_i=0x100 -> next 2 responses dropped; first output has out_pc_o=0x100; pfb_busy_o=1 until discards done.
REQ-034 instr_ready_i=0 for 3 cycles -> instr_addr_o stable across stall; grant on 4th cycle advances address by 4.
REQ-035 rst_i pulse with 2 outstanding -> all outputs at reset values immediately; stray instr_valid_i afterwards produces no out_valid_o.
REQ-036 BETA_PFB_BYPASS_EN defined, FIFO empty, out_ready_i=1 -> response visible on out_instr_o in the same cycle and pfb_count_o stays 0; undefined -> one cycle later.
